timer_bus_initiator: RTL and testbench

- Bus initiator for the timer peripheral's simple register bus. It drives addr, wr_en, rd_en and wdata, and samples rdata.
- Accepts queued READ, WRITE and POLL commands from a host-side valid/ready port and executes them one at a time.
- Returns one response per command, in order. Illegal accesses are rejected with an error response and no bus activity.
- Sits between the CPU-side glue (or a test sequencer) and the timer register block.

---
 rtl/timer_bus_initiator.sv | 178 +++++++++++++++++
 tb/tb_timer_bus_initiator.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bus_initiator.sv
// Register-bus initiator for the timer peripheral: queues READ/WRITE/POLL
// commands, runs them one at a time on the bus and returns one response per command.
module timer_bus_initiator #(
    parameter int FIFO_DEPTH   = 4,
    parameter int POLL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [3:0]  bus_addr,
    output logic        bus_wr_en,
    output logic        bus_rd_en,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, POLL_GAP, RESP} state_t;

    state_t state, state_n;

    logic [37:0]   fifo_mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [1:0]    head_op;
    logic [3:0]    head_addr;
    logic [31:0]   head_data;
    logic          head_legal;

    logic [1:0]    cur_op, cur_op_n;
    logic [31:0]   mask, mask_n;
    logic [CW-1:0] poll_cnt, poll_cnt_n, poll_cnt_inc;
    logic [3:0]    addr_n;
    logic [31:0]   wdata_n, rdata_n;
    logic          wr_n, rd_n, err_n;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;

    assign head_op   = fifo_mem[rd_ptr[PW-1:0]][37:36];
    assign head_addr = fifo_mem[rd_ptr[PW-1:0]][35:32];
    assign head_data = fifo_mem[rd_ptr[PW-1:0]][31:0];
    assign head_legal = (head_addr[1:0] == 2'b00) && (head_op != 2'b11) &&
                        !(head_op == OP_WRITE && head_addr == 4'h8);

    assign poll_cnt_inc = poll_cnt + 1'b1;
    assign rsp_valid    = (state == RESP);
    assign busy         = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PW-1:0]] <= {cmd_op, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cur_op    <= OP_READ;
            mask      <= '0;
            poll_cnt  <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wr_en <= 1'b0;
            bus_rd_en <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cur_op    <= cur_op_n;
            mask      <= mask_n;
            poll_cnt  <= poll_cnt_n;
            bus_addr  <= addr_n;
            bus_wdata <= wdata_n;
            bus_wr_en <= wr_n;
            bus_rd_en <= rd_n;
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
        end
    end

    // Next-state logic also computes the next value of every registered bus/response output.
    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        cur_op_n   = cur_op;
        mask_n     = mask;
        poll_cnt_n = poll_cnt;
        addr_n     = bus_addr;
        wdata_n    = bus_wdata;
        wr_n       = 1'b0;
        rd_n       = 1'b0;
        rdata_n    = rsp_rdata;
        err_n      = rsp_err;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    poll_cnt_n = '0;
                    cur_op_n   = head_op;
                    mask_n     = head_data;
                    if (head_legal) begin
                        addr_n  = head_addr;
                        state_n = ACCESS;
                        if (head_op == OP_WRITE) begin
                            wdata_n = head_data;
                            wr_n    = 1'b1;
                        end else begin
                            rd_n = 1'b1;
                        end
                    end else begin
                        rdata_n = '0;
                        err_n   = 1'b1;
                        state_n = RESP;
                    end
                end
            end
            ACCESS: begin
                case (cur_op)
                    OP_READ: begin
                        rdata_n = bus_rdata;
                        err_n   = 1'b0;
                        state_n = RESP;
                    end
                    OP_WRITE: begin
                        rdata_n = '0;
                        err_n   = 1'b0;
                        state_n = RESP;
                    end
                    default: begin
                        poll_cnt_n = poll_cnt_inc;
                        if ((bus_rdata & mask) != '0) begin
                            rdata_n = bus_rdata;
                            err_n   = 1'b0;
                            state_n = RESP;
                        end else if (poll_cnt_inc == CW'(POLL_TIMEOUT)) begin
                            rdata_n = bus_rdata;
                            err_n   = 1'b1;
                            state_n = RESP;
                        end else begin
                            state_n = POLL_GAP;
                        end
                    end
                endcase
            end
            POLL_GAP: begin
                rd_n    = 1'b1;
                state_n = ACCESS;
            end
            RESP: begin
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_timer_bus_initiator.sv
// Directed bench for timer_bus_initiator with a small timer register responder model.
module tb_timer_bus_initiator;

    localparam logic [31:0] COUNT_VAL = 32'h0000_1234;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [3:0]  cmd_addr = 4'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [3:0]  bus_addr;
    logic        bus_wr_en;
    logic        bus_rd_en;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;

    timer_bus_initiator #(.FIFO_DEPTH(4), .POLL_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: CTRL/LOAD are plain storage, COUNT is fixed, STATUS bit0 rises on the 5th read when enabled.
    logic [31:0] reg0, reg4;
    int status_reads = 0;
    int status_base = 0;
    logic poll_success = 1'b0;

    always @(posedge clk) begin
        if (bus_wr_en && bus_addr == 4'h0) reg0 <= bus_wdata;
        if (bus_wr_en && bus_addr == 4'h4) reg4 <= bus_wdata;
        if (bus_rd_en && bus_addr == 4'hC) status_reads <= status_reads + 1;
    end

    always_comb begin
        bus_rdata = 32'h0;
        case (bus_addr)
            4'h0: bus_rdata = reg0;
            4'h4: bus_rdata = reg4;
            4'h8: bus_rdata = COUNT_VAL;
            4'hC: bus_rdata = (poll_success && (status_reads - status_base) >= 4) ? 32'h1 : 32'h0;
            default: bus_rdata = 32'h0;
        endcase
    end

    int wr_cnt = 0, rd_cnt = 0, adj_rd = 0, both_err = 0;
    int wr_cyc = 0, last_rd_cyc = -10;
    logic [3:0]  wr_addr_seen = 4'h0;
    logic [31:0] wr_data_seen = 32'h0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_wr_en) begin
                wr_cnt++;
                wr_cyc = cyc;
                wr_addr_seen = bus_addr;
                wr_data_seen = bus_wdata;
            end
            if (bus_rd_en) begin
                if (cyc - last_rd_cyc == 1) adj_rd++;
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (bus_wr_en && bus_rd_en) both_err++;
        end
    end

    task automatic push(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] wd,
                        output int pc);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; failures++;
            $display("[TB] FAIL push_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        pc = cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] rd, output logic er, output int rc);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("[TB] FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
        end
        rd = rsp_rdata; er = rsp_err; rc = cyc;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_wr_en, bus_rd_en, rsp_valid, rsp_err} !== 4'b0 || bus_addr !== 4'h0 ||
            bus_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: wr=%0b rd=%0b vld=%0b err=%0b addr=%h wd=%h rd=%h required all 0",
                     bus_wr_en, bus_rd_en, rsp_valid, rsp_err, bus_addr, bus_wdata, rsp_rdata);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready_busy: ready=%0b busy=%0b required 1/0", cmd_ready, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int pc, rc, wb;
        logic [31:0] rd;
        logic er;
        wb = wr_cnt;
        push(2'b01, 4'h0, 32'h3, pc);
        get_rsp(rd, er, rc);
        checks++;
        if (wr_cnt - wb != 1 || wr_addr_seen !== 4'h0 || wr_data_seen !== 32'h3) begin
            failures++;
            $display("[TB] FAIL write_strobe: pulses=%0d addr=%h data=%h required 1/0/3",
                     wr_cnt - wb, wr_addr_seen, wr_data_seen);
        end
        checks++;
        if (wr_cyc != pc + 2 || rc != pc + 3) begin
            failures++;
            $display("[TB] FAIL write_latency: strobe=+%0d rsp=+%0d required +2/+3", wr_cyc - pc, rc - pc);
        end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            failures++;
            $display("[TB] FAIL write_rsp: rdata=%h err=%0b required 0/0", rd, er);
        end
        push(2'b00, 4'h0, 32'h0, pc);
        get_rsp(rd, er, rc);
        checks++;
        if (rd !== 32'h3 || er !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_rsp: rdata=%h err=%0b required 3/0", rd, er);
        end
        checks++;
        if (last_rd_cyc != pc + 2 || rc != pc + 3) begin
            failures++;
            $display("[TB] FAIL read_latency: strobe=+%0d rsp=+%0d required +2/+3", last_rd_cyc - pc, rc - pc);
        end
    endtask

    task automatic test_model_regs();
        int pc, rc;
        logic [31:0] rd;
        logic er;
        logic [31:0] exp_rd [3];
        exp_rd = '{32'h0, 32'hDEADBEEF, COUNT_VAL};
        push(2'b01, 4'h4, 32'hDEADBEEF, pc);
        push(2'b00, 4'h4, 32'h0, pc);
        push(2'b00, 4'h8, 32'h0, pc);
        for (int i = 0; i < 3; i++) begin
            get_rsp(rd, er, rc);
            checks++;
            if (rd !== exp_rd[i] || er !== 1'b0) begin
                failures++;
                $display("[TB] FAIL model_rsp%0d: rdata=%h err=%0b required %h/0", i, rd, er, exp_rd[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int pc, rc, wb, rb;
        logic [31:0] rd;
        logic er;
        wb = wr_cnt; rb = rd_cnt;
        push(2'b01, 4'h8, 32'h55, pc);
        push(2'b00, 4'h5, 32'h0, pc);
        push(2'b11, 4'h0, 32'h0, pc);
        for (int i = 0; i < 3; i++) begin
            get_rsp(rd, er, rc);
            checks++;
            if (rd !== 32'h0 || er !== 1'b1) begin
                failures++;
                $display("[TB] FAIL illegal_rsp%0d: rdata=%h err=%0b required 0/1", i, rd, er);
            end
        end
        checks++;
        if (wr_cnt != wb || rd_cnt != rb) begin
            failures++;
            $display("[TB] FAIL illegal_no_strobe: wr=%0d rd=%0d required 0/0", wr_cnt - wb, rd_cnt - rb);
        end
    endtask

    task automatic test_poll_success();
        int pc, rc, rb, ab;
        logic [31:0] rd;
        logic er;
        rb = rd_cnt; ab = adj_rd;
        status_base = status_reads;
        poll_success = 1'b1;
        push(2'b10, 4'hC, 32'h1, pc);
        get_rsp(rd, er, rc);
        poll_success = 1'b0;
        checks++;
        if (rd_cnt - rb != 5 || adj_rd != ab || last_rd_cyc != pc + 10) begin
            failures++;
            $display("[TB] FAIL poll_pulses: count=%0d adjacent=%0d last=+%0d required 5/0/+10",
                     rd_cnt - rb, adj_rd - ab, last_rd_cyc - pc);
        end
        checks++;
        if (rd !== 32'h1 || er !== 1'b0 || rc != pc + 11) begin
            failures++;
            $display("[TB] FAIL poll_rsp: rdata=%h err=%0b at=+%0d required 1/0/+11", rd, er, rc - pc);
        end
    endtask

    task automatic test_poll_timeout();
        int pc, rc, rb, ab;
        logic [31:0] rd;
        logic er;
        rb = rd_cnt; ab = adj_rd;
        push(2'b10, 4'hC, 32'h1, pc);
        get_rsp(rd, er, rc);
        checks++;
        if (rd_cnt - rb != 8 || adj_rd != ab || last_rd_cyc != pc + 16) begin
            failures++;
            $display("[TB] FAIL timeout_pulses: count=%0d adjacent=%0d last=+%0d required 8/0/+16",
                     rd_cnt - rb, adj_rd - ab, last_rd_cyc - pc);
        end
        checks++;
        if (rd !== 32'h0 || er !== 1'b1 || rc != pc + 17) begin
            failures++;
            $display("[TB] FAIL timeout_rsp: rdata=%h err=%0b at=+%0d required 0/1/+17", rd, er, rc - pc);
        end
        checks++;
        if (both_err != 0) begin
            failures++;
            $display("[TB] FAIL strobe_overlap: cycles=%0d required 0", both_err);
        end
    endtask

    task automatic test_back_to_back();
        int accepted = 0, n, pc, rc;
        logic [31:0] rd;
        logic er;
        logic [1:0]  ops [6];
        logic [31:0] dat [6];
        logic [31:0] exp_rd [5];
        logic [3:0]  adr [6];
        ops = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
        adr = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
        dat = '{32'hA1, 32'h0, 32'hA2, 32'h0, 32'h0, 32'hA3};
        exp_rd = '{32'h0, 32'hA1, 32'h0, 32'hA2, 32'hDEADBEEF};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = ops[i]; cmd_addr = adr[i]; cmd_wdata = dat[i];
            n = 0;
            while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
            if (!cmd_ready) break;
            accepted++;
            @(posedge clk); #1;
        end
        checks++;
        if (accepted != 5 || cmd_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fifo_fill: accepted=%0d ready=%0b required 5/0", accepted, cmd_ready);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            get_rsp(rd, er, rc);
            checks++;
            if (rd !== exp_rd[i] || er !== 1'b0) begin
                failures++;
                $display("[TB] FAIL drain_rsp%0d: rdata=%h err=%0b required %h/0", i, rd, er, exp_rd[i]);
            end
        end
        // Reset while a response is pending.
        push(2'b00, 4'h0, 32'h0, pc);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rsp: valid=%0b rdata=%h required 0/0", rsp_valid, rsp_rdata);
        end
        @(negedge clk) rst_n = 1'b1;
        // Reset in the middle of a POLL that would otherwise time out.
        push(2'b10, 4'hC, 32'h1, pc);
        n = 0;
        @(negedge clk);
        while (!bus_rd_en && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bus_rd_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL poll_active: rd_en=%0b busy=%0b required 1/1", bus_rd_en, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_rd_en !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_poll: rd_en=%0b valid=%0b required 0/0", bus_rd_en, rsp_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset: ready=%0b busy=%0b valid=%0b required 1/0/0",
                     cmd_ready, busy, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_model_regs();
        test_illegal();
        test_poll_success();
        test_poll_timeout();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
